pwm_output_ctrl: RTL and testbench

//   Consumer of the SPI register bank. Turns the five configuration bytes (output

---
 rtl/pwm_output_ctrl.sv | 90 +++++++++
 tb/tb_pwm_output_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_output_ctrl.sv
// pwm_output_ctrl: 16 registered pins, each forced low, forced high or driven by a shared 8-bit PWM.
// Define PWM_SYNC_UPDATE_EN to shadow the duty cycle and load it only when the PWM period wraps.
module pwm_output_ctrl #(
  parameter int CLK_DIV = 3000,
  parameter int DIV_W   = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] pin_out,
  output logic        pwm_period_start
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [7:0]       CNT_LAST = 8'd254;

  logic [DIV_W-1:0] div_cnt;
  logic [7:0]       pwm_cnt;
  logic [7:0]       duty_active;
  logic             tick;
  logic             wrap;
  logic             pwm_sig;
  logic [15:0]      en_out;
  logic [15:0]      en_pwm;
  logic [15:0]      pin_next;

  assign tick = (div_cnt == DIV_LAST);
  assign wrap = tick && (pwm_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // The period counter stops at 254 so that a duty of 255 can mean "always on".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt          <= '0;
      pwm_period_start <= 1'b0;
    end else begin
      pwm_period_start <= wrap;
      if (wrap) begin
        pwm_cnt <= '0;
      end else if (tick) begin
        pwm_cnt <= pwm_cnt + 8'd1;
      end
    end
  end

`ifdef PWM_SYNC_UPDATE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_active <= '0;
    end else if (wrap) begin
      duty_active <= pwm_duty_cycle;
    end
  end
`else
  assign duty_active = pwm_duty_cycle;
`endif

  assign pwm_sig = (duty_active == 8'hFF) | (pwm_cnt < duty_active);
  assign en_out  = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm  = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  always_comb begin
    pin_next = '0;
    for (int i = 0; i < 16; i++) begin
      pin_next[i] = en_out[i] ? (en_pwm[i] ? pwm_sig : 1'b1) : 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pin_out <= '0;
    end else begin
      pin_out <= pin_next;
    end
  end

endmodule

// File: tb/tb_pwm_output_ctrl.sv
// tb_pwm_output_ctrl: vector table plus multi-period PWM sequences for pwm_output_ctrl (CLK_DIV=4).
// Expected values go into a scoreboard queue and are popped when the DUT output is sampled.
module tb_pwm_output_ctrl;

  localparam int CLK_DIV = 4;
  localparam int PERIOD  = 255 * CLK_DIV;
`ifdef PWM_SYNC_UPDATE_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  en_reg_out_7_0 = '0;
  logic [7:0]  en_reg_out_15_8 = '0;
  logic [7:0]  en_reg_pwm_7_0 = '0;
  logic [7:0]  en_reg_pwm_15_8 = '0;
  logic [7:0]  pwm_duty_cycle = '0;
  logic [15:0] pin_out;
  logic        pwm_period_start;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [15:0] en_out;
    logic [15:0] en_pwm;
    logic [7:0]  duty;
    logic [15:0] exp_pin;
  } vec_t;

  vec_t vecs[8];

  pwm_output_ctrl #(.CLK_DIV(CLK_DIV), .DIV_W(3)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .en_reg_out_7_0   (en_reg_out_7_0),
    .en_reg_out_15_8  (en_reg_out_15_8),
    .en_reg_pwm_7_0   (en_reg_pwm_7_0),
    .en_reg_pwm_15_8  (en_reg_pwm_15_8),
    .pwm_duty_cycle   (pwm_duty_cycle),
    .pin_out          (pin_out),
    .pwm_period_start (pwm_period_start)
  );

  always #5 clk = ~clk;

  task automatic push_exp(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual);
    logic [31:0] want;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, nothing queued", name, actual);
    end else begin
      want = exp_q.pop_front();
      if (actual !== want) begin
        miscompares++;
        $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, want);
      end
    end
  endtask

  task automatic drive(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
    en_reg_out_7_0  = eo[7:0];
    en_reg_out_15_8 = eo[15:8];
    en_reg_pwm_7_0  = ep[7:0];
    en_reg_pwm_15_8 = ep[15:8];
    pwm_duty_cycle  = d;
  endtask

  task automatic applyStimulus(input vec_t v, input string name);
    @(negedge clk);
    drive(v.en_out, v.en_pwm, v.duty);
    push_exp(32'(v.exp_pin));
    @(negedge clk);
    checkOutput(name, 32'(pin_out));
  endtask

  // Returns the number of negedges until pwm_period_start is seen, 0 on timeout.
  task automatic wait_period_start(output int n);
    n = 0;
    for (int k = 1; k <= PERIOD + 80; k++) begin
      @(negedge clk);
      if (pwm_period_start) begin
        n = k;
        return;
      end
    end
  endtask

  initial begin
    int n;
    int high;
    int low;
    int bad;
    int starts;
    int found;

    vecs[0] = '{16'h00FF, 16'h0000, 8'h00, 16'h00FF};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 8'h00, 16'h0000};
    vecs[2] = '{16'hFFFF, 16'h0F0F, 8'h00, 16'hF0F0};
    vecs[3] = '{16'h0000, 16'hFFFF, 8'h00, 16'h0000};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 8'hFF, 16'hFFFF};
    vecs[5] = '{16'hA5A5, 16'hFF00, 8'hFF, 16'hA5A5};
    vecs[6] = '{16'h1234, 16'h0000, 8'hFF, 16'h1234};
    vecs[7] = '{16'h0000, 16'hFFFF, 8'hFF, 16'h0000};

    // Reset held: outputs stay zero whatever the inputs do
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(16'($urandom), 16'($urandom), 8'($urandom));
      push_exp(32'h0);
      checkOutput("reset_pin_out", 32'(pin_out));
      push_exp(32'h0);
      checkOutput("reset_period_start", 32'(pwm_period_start));
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(16'h0000, 16'h0000, 8'h00);
    wait_period_start(n);
    push_exp(PERIOD);
    checkOutput("first_period_after_reset", n);

    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        pwm_duty_cycle = 8'hFF;
        wait_period_start(n);
        push_exp(1);
        checkOutput("duty_ff_load", 32'(n != 0));
      end
      applyStimulus(vecs[i], $sformatf("vector_%0d", i));
    end

    // Duty FF: constant high over three periods
    @(negedge clk);
    drive(16'hFFFF, 16'hFFFF, 8'hFF);
    @(negedge clk);
    bad = 0;
    starts = 0;
    for (int k = 0; k < 3 * PERIOD; k++) begin
      @(negedge clk);
      if (pin_out != 16'hFFFF) bad++;
      if (pwm_period_start) starts++;
    end
    push_exp(0);
    checkOutput("duty_ff_glitches", bad);
    push_exp(3);
    checkOutput("duty_ff_period_starts", starts);

    // Duty 00: constant low over three periods once loaded
    pwm_duty_cycle = 8'h00;
    wait_period_start(n);
    @(negedge clk);
    bad = 0;
    for (int k = 0; k < 3 * PERIOD; k++) begin
      @(negedge clk);
      if (pin_out != 16'h0000) bad++;
    end
    push_exp(0);
    checkOutput("duty_00_glitches", bad);

    // Duty 80: 512 high, 508 low per period, all pins in step
    pwm_duty_cycle = 8'h80;
    wait_period_start(n);
    wait_period_start(n);
    push_exp(PERIOD);
    checkOutput("period_length_duty_80", n);
    high = 0;
    low = 0;
    bad = 0;
    for (int k = 0; k < PERIOD; k++) begin
      if (k > 0) @(negedge clk);
      if (pin_out == 16'hFFFF) high++;
      else if (pin_out == 16'h0000) low++;
      else bad++;
    end
    push_exp(512);
    checkOutput("duty_80_high", high);
    push_exp(508);
    checkOutput("duty_80_low", low);
    push_exp(0);
    checkOutput("duty_80_pins_split", bad);
    @(negedge clk);
    push_exp(1);
    checkOutput("duty_80_next_start", 32'(pwm_period_start));

    // Output disable wins over PWM select, effective next clk
    drive(16'h0008, 16'h0008, 8'h80);
    found = 0;
    for (int k = 0; k < 2 * PERIOD && found == 0; k++) begin
      @(negedge clk);
      if (pin_out[3]) found = 1;
    end
    push_exp(1);
    checkOutput("pin3_pwm_high_seen", found);
    push_exp(32'h0008);
    checkOutput("pin3_only_active", 32'(pin_out));
    drive(16'h0000, 16'h0008, 8'h80);
    @(negedge clk);
    push_exp(0);
    checkOutput("pin3_disable_next_clk", 32'(pin_out));
    bad = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      drive(16'h0000, 16'($urandom), 8'h80);
      if (pin_out != 16'h0000) bad++;
    end
    push_exp(0);
    checkOutput("pin3_stays_low", bad);

    // Duty 40 -> C0 at pwm_cnt=100
    drive(16'hFFFF, 16'hFFFF, 8'h40);
    wait_period_start(n);
    wait_period_start(n);
    push_exp(1);
    checkOutput("duty_40_aligned", 32'(n != 0));
    high = 0;
    for (int k = 0; k < PERIOD; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 400) begin
        push_exp(0);
        checkOutput("duty_change_before", 32'(pin_out));
        pwm_duty_cycle = 8'hC0;
      end
      if (k == 401) begin
        push_exp(SYNC ? 32'h0 : 32'hFFFF);
        checkOutput("duty_change_after", 32'(pin_out));
      end
      if (pin_out[0]) high++;
    end
    push_exp(SYNC ? 256 : 624);
    checkOutput("duty_change_period_high", high);
    @(negedge clk);
    push_exp(1);
    checkOutput("duty_change_next_start", 32'(pwm_period_start));
    high = 0;
    for (int k = 0; k < PERIOD; k++) begin
      if (k > 0) @(negedge clk);
      if (pin_out[0]) high++;
    end
    push_exp(768);
    checkOutput("duty_c0_period_high", high);

    // Asynchronous reset mid-period clears state at once
    @(negedge clk);
    drive(16'hFFFF, 16'h0000, 8'hC0);
    repeat (37) @(negedge clk);
    push_exp(32'hFFFF);
    checkOutput("static_high_before_reset", 32'(pin_out));
    #2 rst_n = 1'b0;
    #1;
    push_exp(0);
    checkOutput("async_reset_pin_out", 32'(pin_out));
    push_exp(0);
    checkOutput("async_reset_period_start", 32'(pwm_period_start));
    @(negedge clk);
    rst_n = 1'b1;
    drive(16'hFFFF, 16'hFFFF, 8'hC0);
    n = 0;
    for (int k = 1; k <= PERIOD + 80 && n == 0; k++) begin
      @(negedge clk);
      if (k == 500) begin
        push_exp(SYNC ? 32'h0 : 32'hFFFF);
        checkOutput("first_period_duty_after_reset", 32'(pin_out));
      end
      if (pwm_period_start) n = k;
    end
    push_exp(PERIOD);
    checkOutput("period_after_mid_reset", n);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
